// File: rtl/parity_frame_rx.sv
// parity_frame_rx
//
// Serial frame receiver with parity check. A frame is NUM_BITS data bits,
// first bit first, followed by one parity bit. Each bit is taken on a clock
// edge where wr_en is high. Gaps of any length between bits are allowed.
// When the parity bit arrives, the block does three things on that same edge:
//   - loads the assembled word into data_out,
//   - reports the parity check on parity_err,
//   - pulses data_valid for one cycle.
// A saturating 8-bit counter tracks the number of errored frames.
//
// Parameters
//   NUM_BITS         data bits per frame (2..32)
//   EVEN_PARITY_BIT  1: data + parity carry an even number of ones
//                    0: they carry an odd number of ones
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   data_in     serial bit, sampled when wr_en = 1
//   wr_en       bit qualifier
//   sync        synchronous frame restart; wins over wr_en, drops the bit
//   data_out    last complete word, first-received bit in the MSB
//   data_valid  one-cycle strobe when data_out / parity_err update
//   parity_err  1 = last frame failed the parity check
//   busy        1 while a frame is partially received
//   err_cnt     number of errored frames, saturating at 255

module parity_frame_rx #(
    parameter int unsigned NUM_BITS        = 4,
    parameter bit          EVEN_PARITY_BIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_in,
    input  logic                wr_en,
    input  logic                sync,
    output logic [NUM_BITS-1:0] data_out,
    output logic                data_valid,
    output logic                parity_err,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    localparam int unsigned CntW = $clog2(NUM_BITS + 1);
    // bit_cnt value held just before the last data bit is taken
    localparam logic [CntW-1:0] LastDataCnt = CntW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPar
    } state_e;

    state_e              state_q;
    logic [CntW-1:0]     bit_cnt_q;
    logic [NUM_BITS-1:0] shift_q;
    logic                par_q;

    logic frame_par;
    logic frame_err;

    // Parity over data + parity bit, and its interpretation for the chosen sense
    always_comb begin
        frame_par = par_q ^ data_in;
        frame_err = EVEN_PARITY_BIT ? frame_par : ~frame_par;
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            data_valid <= 1'b0;
            if (sync) begin
                // Drop the partial frame; completed results are kept
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                shift_q   <= '0;
                par_q     <= 1'b0;
            end else if (wr_en) begin
                unique case (state_q)
                    StIdle: begin
                        // Older contents are shifted out before the word completes
                        shift_q   <= {shift_q[NUM_BITS-2:0], data_in};
                        par_q     <= data_in;
                        bit_cnt_q <= CntW'(1);
                        state_q   <= StData;
                    end
                    StData: begin
                        shift_q   <= {shift_q[NUM_BITS-2:0], data_in};
                        par_q     <= par_q ^ data_in;
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                        if (bit_cnt_q == LastDataCnt) begin
                            state_q <= StPar;
                        end
                    end
                    StPar: begin
                        data_out   <= shift_q;
                        parity_err <= frame_err;
                        data_valid <= 1'b1;
                        if (frame_err && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        bit_cnt_q  <= '0;
                        par_q      <= 1'b0;
                        state_q    <= StIdle;
                    end
                    default: begin
                        state_q   <= StIdle;
                        bit_cnt_q <= '0;
                        par_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Testbench for parity_frame_rx. Two instances share stimulus:
// one with even parity and one with odd parity.

module tb_parity_frame_rx;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         data_in;
    logic         wr_en;
    logic         sync;

    logic [N-1:0] e_data, o_data;
    logic         e_valid, o_valid;
    logic         e_err, o_err;
    logic         e_busy, o_busy;
    logic [7:0]   e_cnt, o_cnt;

    parity_frame_rx #(.NUM_BITS(N), .EVEN_PARITY_BIT(1'b1)) dut_e (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .sync       (sync),
        .data_out   (e_data),
        .data_valid (e_valid),
        .parity_err (e_err),
        .busy       (e_busy),
        .err_cnt    (e_cnt)
    );

    parity_frame_rx #(.NUM_BITS(N), .EVEN_PARITY_BIT(1'b0)) dut_o (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .sync       (sync),
        .data_out   (o_data),
        .data_valid (o_valid),
        .parity_err (o_err),
        .busy       (o_busy),
        .err_cnt    (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pending bits of the current frame and the last results
    bit           m_q[$];
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_err_e, m_err_o;
    int           m_cnt_e, m_cnt_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_err_e = 1'b0;
        m_err_o = 1'b0;
        m_cnt_e = 0;
        m_cnt_o = 0;
    endtask

    task automatic model_edge(input logic d, input logic w, input logic s);
        int ones;
        logic [N-1:0] word;
        m_valid = 1'b0;
        if (s) begin
            m_q.delete();
        end else if (w) begin
            m_q.push_back(d);
            if (m_q.size() == N + 1) begin
                ones = 0;
                word = '0;
                for (int i = 0; i < N; i++) word = (word << 1) | N'(m_q[i]);
                for (int i = 0; i <= N; i++) ones += int'(m_q[i]);
                m_data  = word;
                m_err_e = (ones % 2) != 0;
                m_err_o = (ones % 2) == 0;
                if (m_err_e && m_cnt_e < 255) m_cnt_e++;
                if (m_err_o && m_cnt_o < 255) m_cnt_o++;
                m_valid = 1'b1;
                m_q.delete();
            end
        end
    endtask

    task automatic compare_all();
        logic m_busy;
        m_busy = (m_q.size() != 0);
        chk("e_valid", 32'(e_valid), 32'(m_valid));
        chk("e_data",  32'(e_data),  32'(m_data));
        chk("e_err",   32'(e_err),   32'(m_err_e));
        chk("e_busy",  32'(e_busy),  32'(m_busy));
        chk("e_cnt",   32'(e_cnt),   32'(m_cnt_e));
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("o_data",  32'(o_data),  32'(m_data));
        chk("o_err",   32'(o_err),   32'(m_err_o));
        chk("o_busy",  32'(o_busy),  32'(m_busy));
        chk("o_cnt",   32'(o_cnt),   32'(m_cnt_o));
    endtask

    // One clock: drive at negedge, model the edge, check 1 time unit later
    task automatic step(input logic d, input logic w, input logic s);
        @(negedge clk);
        data_in = d;
        wr_en   = w;
        sync    = s;
        @(posedge clk);
        model_edge(d, w, s);
        #1;
        data_in = 1'b0;
        wr_en   = 1'b0;
        sync    = 1'b0;
        compare_all();
    endtask

    task automatic send_frame(input logic [N-1:0] word, input logic par);
        for (int i = N - 1; i >= 0; i--) step(word[i], 1'b1, 1'b0);
        step(par, 1'b1, 1'b0);
    endtask

    // Assert reset right now (no clock), check outputs clear at once
    task automatic async_reset();
        rst = 1'b1;
        #1;
        chk("rst_e_data",  32'(e_data),  32'd0);
        chk("rst_e_valid", 32'(e_valid), 32'd0);
        chk("rst_e_err",   32'(e_err),   32'd0);
        chk("rst_e_busy",  32'(e_busy),  32'd0);
        chk("rst_e_cnt",   32'(e_cnt),   32'd0);
        chk("rst_o_busy",  32'(o_busy),  32'd0);
        chk("rst_o_cnt",   32'(o_cnt),   32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        async_reset();
    endtask

    typedef struct {
        logic [N-1:0] data;
        logic         par;
        logic [N-1:0] exp_data;
        logic         exp_err_e;
        logic         exp_err_o;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int vq[$];
        int eq[$];
        logic [14:0] pat;
        logic [N-1:0] w;

        rst     = 1'b1;
        data_in = 1'b0;
        wr_en   = 1'b0;
        sync    = 1'b0;

        vecs[0] = '{4'hB, 1'b1, 4'hB, 1'b0, 1'b1};
        vecs[1] = '{4'hB, 1'b0, 4'hB, 1'b1, 1'b0};
        vecs[2] = '{4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{4'hF, 1'b0, 4'hF, 1'b0, 1'b1};
        vecs[4] = '{4'h6, 1'b0, 4'h6, 1'b0, 1'b1};
        vecs[5] = '{4'h5, 1'b1, 4'h5, 1'b1, 1'b0};

        async_reset();

        // Table-driven frames, back to back
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par);
            chk("tbl_valid", 32'(e_valid), 32'd1);
            chk("tbl_data",  32'(e_data),  32'(vecs[i].exp_data));
            chk("tbl_err_e", 32'(e_err),   32'(vecs[i].exp_err_e));
            chk("tbl_err_o", 32'(o_err),   32'(vecs[i].exp_err_o));
        end
        step(1'b0, 1'b0, 1'b0);
        chk("tbl_valid_drop", 32'(e_valid), 32'd0);

        // Bits with 3-cycle gaps; busy holds through gaps
        do_reset();
        pat = 15'b000_0000_0010111;
        for (int i = 4; i >= 0; i--) begin
            step(pat[i], 1'b1, 1'b0);
            if (i != 0) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 1'b0);
                    chk("gap_busy", 32'(e_busy), 32'd1);
                end
            end
        end
        chk("gap_valid", 32'(e_valid), 32'd1);
        chk("gap_data",  32'(e_data),  32'hB);
        chk("gap_err",   32'(e_err),   32'd0);
        chk("gap_busy0", 32'(e_busy),  32'd0);
        chk("gap_cnt",   32'(e_cnt),   32'd0);

        // Three frames with wr_en always high: B/1, 0/1, F/0
        do_reset();
        pat = 15'b10111_00001_11110;
        for (int i = 0; i < 15; i++) begin
            step(pat[14-i], 1'b1, 1'b0);
            if (e_valid) begin
                vq.push_back(i + 1);
                eq.push_back(int'(e_err));
            end
        end
        chk("b2b_nvalid", 32'(vq.size()), 32'd3);
        if (vq.size() == 3) begin
            chk("b2b_cyc0", 32'(vq[0]), 32'd5);
            chk("b2b_cyc1", 32'(vq[1]), 32'd10);
            chk("b2b_cyc2", 32'(vq[2]), 32'd15);
            chk("b2b_err0", 32'(eq[0]), 32'd0);
            chk("b2b_err1", 32'(eq[1]), 32'd1);
            chk("b2b_err2", 32'(eq[2]), 32'd0);
        end
        chk("b2b_cnt", 32'(e_cnt), 32'd1);

        // Reset mid-frame after two data bits
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        #2;
        async_reset();
        send_frame(4'h6, 1'b0);
        chk("rst_mid_data", 32'(e_data), 32'h6);
        chk("rst_mid_err",  32'(e_err),  32'd0);

        // sync with wr_en after three bits: bit dropped, no strobe
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("sync_valid", 32'(e_valid), 32'd0);
        chk("sync_busy",  32'(e_busy),  32'd0);
        chk("sync_hold",  32'(e_data),  32'h6);
        send_frame(4'h9, 1'b0);
        chk("sync_data", 32'(e_data), 32'h9);
        chk("sync_err",  32'(e_err),  32'd0);

        // 260 errored frames (even sense) to saturate the counter
        for (int k = 0; k < 260; k++) begin
            w = N'($urandom);
            send_frame(w, ~(^w));
            chk("sat_err", 32'(e_err), 32'd1);
        end
        chk("sat_cnt", 32'(e_cnt), 32'd255);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom), ($urandom_range(99) < 70), ($urandom_range(99) < 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
